// File: rtl/mano_pkg.sv
// Shared encodings for the Mano control unit: bus/ALU select codes, opcodes,
// register-reference masks and the timing-state enum.
package mano_pkg;

  localparam logic [2:0] BUS_NONE = 3'b000;
  localparam logic [2:0] BUS_AR   = 3'b001;
  localparam logic [2:0] BUS_PC   = 3'b010;
  localparam logic [2:0] BUS_DR   = 3'b011;
  localparam logic [2:0] BUS_AC   = 3'b100;
  localparam logic [2:0] BUS_IR   = 3'b101;
  localparam logic [2:0] BUS_TR   = 3'b110;
  localparam logic [2:0] BUS_MEM  = 3'b111;

  localparam logic [2:0] ALU_DR   = 3'b000;
  localparam logic [2:0] ALU_AND  = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_COM  = 3'b011;
  localparam logic [2:0] ALU_SHR  = 3'b100;
  localparam logic [2:0] ALU_SHL  = 3'b101;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_LDA    = 3'd2;
  localparam logic [2:0] OP_STA    = 3'd3;
  localparam logic [2:0] OP_BUN    = 3'd4;
  localparam logic [2:0] OP_BSA    = 3'd5;
  localparam logic [2:0] OP_ISZ    = 3'd6;
  localparam logic [2:0] OP_REGREF = 3'd7;

  localparam logic [11:0] RR_CLA = 12'h800;
  localparam logic [11:0] RR_CLE = 12'h400;
  localparam logic [11:0] RR_CMA = 12'h200;
  localparam logic [11:0] RR_CME = 12'h100;
  localparam logic [11:0] RR_CIR = 12'h080;
  localparam logic [11:0] RR_CIL = 12'h040;
  localparam logic [11:0] RR_INC = 12'h020;
  localparam logic [11:0] RR_SPA = 12'h010;
  localparam logic [11:0] RR_SNA = 12'h008;
  localparam logic [11:0] RR_SZA = 12'h004;
  localparam logic [11:0] RR_SZE = 12'h002;
  localparam logic [11:0] RR_HLT = 12'h001;

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6} tstate_t;

endpackage

// File: rtl/mano_decode.sv
// Combinational instruction decode: memory-reference opcode one-hot,
// register-reference one-hot (highest set bit wins), regref / I/O class flags.
module mano_decode
  import mano_pkg::*;
(
  input  logic [15:0] ir,
  output logic [6:0]  mem_op,
  output logic [11:0] rr_oh,
  output logic        is_regref,
  output logic        is_io
);

  always_comb begin
    mem_op = '0;
    for (int k = 0; k < 7; k++) begin
      mem_op[k] = (ir[14:12] == 3'(k));
    end
    // Ascending scan so the highest set bit is the last one written.
    rr_oh = '0;
    for (int b = 0; b < 12; b++) begin
      if (ir[b]) begin
        rr_oh = 12'd1 << b;
      end
    end
    is_regref = (ir[14:12] == OP_REGREF) && !ir[15];
    is_io     = (ir[14:12] == OP_REGREF) &&  ir[15];
  end

endmodule

// File: rtl/mano_control_unit.sv
// Hardwired control for the Mano basic computer: sequence counter, indirect
// flip-flop and halt flag, plus every datapath/memory strobe decoded per T-state.
module mano_control_unit
  import mano_pkg::*;
#(
  parameter int SC_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [15:0]     ir,
  input  logic            ac_zero,
  input  logic            ac_msb,
  input  logic            dr_zero,
  input  logic            e,
  output logic            ar_ld,
  output logic            ar_inr,
  output logic            ar_clr,
  output logic            pc_ld,
  output logic            pc_inr,
  output logic            pc_clr,
  output logic            dr_ld,
  output logic            dr_inr,
  output logic            ac_ld,
  output logic            ac_inr,
  output logic            ac_clr,
  output logic            ir_ld,
  output logic            e_ld,
  output logic            e_clr,
  output logic            e_cmp,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [2:0]      bus_sel,
  output logic [2:0]      alu_func,
  output logic [SC_W-1:0] sc,
  output logic            halted
);

  tstate_t     state, state_nxt;
  logic        i_ff;
  logic        active;
  logic        sc_clr;
  logic        halt_set;
  logic [6:0]  mem_op;
  logic [11:0] rr_oh;
  logic        is_regref;
  logic        is_io;

  mano_decode u_decode (
    .ir        (ir),
    .mem_op    (mem_op),
    .rr_oh     (rr_oh),
    .is_regref (is_regref),
    .is_io     (is_io)
  );

  assign sc     = SC_W'(state);
  assign active = run && !halted && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= T0;
      i_ff   <= 1'b0;
      halted <= 1'b0;
    end else if (active) begin
      state <= state_nxt;
      if (state == T2) i_ff <= ir[15];
      if (halt_set) halted <= 1'b1;
    end
  end

  always_comb begin
    ar_ld = 1'b0;  ar_inr = 1'b0; ar_clr = 1'b0;
    pc_ld = 1'b0;  pc_inr = 1'b0; pc_clr = 1'b0;
    dr_ld = 1'b0;  dr_inr = 1'b0;
    ac_ld = 1'b0;  ac_inr = 1'b0; ac_clr = 1'b0;
    ir_ld = 1'b0;  e_ld   = 1'b0; e_clr  = 1'b0; e_cmp = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    bus_sel  = BUS_NONE;
    alu_func = ALU_DR;
    sc_clr   = 1'b0;
    halt_set = 1'b0;

    if (active) begin
      case (state)
        T0: begin bus_sel = BUS_PC; ar_ld = 1'b1; end
        T1: begin bus_sel = BUS_MEM; mem_rd = 1'b1; ir_ld = 1'b1; pc_inr = 1'b1; end
        T2: begin bus_sel = BUS_IR; ar_ld = 1'b1; end
        T3: begin
          if (is_regref) begin
            sc_clr = 1'b1;
            case (rr_oh)
              RR_CLA: ac_clr = 1'b1;
              RR_CLE: e_clr  = 1'b1;
              RR_CMA: begin alu_func = ALU_COM; ac_ld = 1'b1; end
              RR_CME: e_cmp  = 1'b1;
              RR_CIR: begin alu_func = ALU_SHR; ac_ld = 1'b1; e_ld = 1'b1; end
              RR_CIL: begin alu_func = ALU_SHL; ac_ld = 1'b1; e_ld = 1'b1; end
              RR_INC: ac_inr = 1'b1;
              RR_SPA: pc_inr = !ac_msb;
              RR_SNA: pc_inr = ac_msb;
              RR_SZA: pc_inr = ac_zero;
              RR_SZE: pc_inr = !e;
              RR_HLT: halt_set = 1'b1;
              default: ;
            endcase
          end else if (is_io) begin
            sc_clr = 1'b1;
          end else if (i_ff) begin
            bus_sel = BUS_MEM; mem_rd = 1'b1; ar_ld = 1'b1;
          end
        end
        T4: begin
          if (mem_op[OP_AND] || mem_op[OP_ADD] || mem_op[OP_LDA] || mem_op[OP_ISZ]) begin
            bus_sel = BUS_MEM; mem_rd = 1'b1; dr_ld = 1'b1;
          end else if (mem_op[OP_STA]) begin
            bus_sel = BUS_AC; mem_wr = 1'b1; sc_clr = 1'b1;
          end else if (mem_op[OP_BUN]) begin
            bus_sel = BUS_AR; pc_ld = 1'b1; sc_clr = 1'b1;
          end else if (mem_op[OP_BSA]) begin
            bus_sel = BUS_PC; mem_wr = 1'b1; ar_inr = 1'b1;
          end else begin
            sc_clr = 1'b1;
          end
        end
        T5: begin
          sc_clr = 1'b1;
          if (mem_op[OP_AND]) begin
            alu_func = ALU_AND; ac_ld = 1'b1;
          end else if (mem_op[OP_ADD]) begin
            alu_func = ALU_ADD; ac_ld = 1'b1; e_ld = 1'b1;
          end else if (mem_op[OP_LDA]) begin
            alu_func = ALU_DR; ac_ld = 1'b1;
          end else if (mem_op[OP_BSA]) begin
            bus_sel = BUS_AR; pc_ld = 1'b1;
          end else if (mem_op[OP_ISZ]) begin
            dr_inr = 1'b1; sc_clr = 1'b0;
          end
        end
        T6: begin
          // dr_zero here already reflects the DR incremented in T5.
          bus_sel = BUS_DR; mem_wr = 1'b1; pc_inr = dr_zero; sc_clr = 1'b1;
        end
        default: sc_clr = 1'b1;
      endcase
    end

    state_nxt = sc_clr ? T0 : tstate_t'(state + 3'd1);
  end

endmodule

// File: tb/tb_mano_control_unit.sv
// Bench for mano_control_unit: directed vector table, hand-written reset/halt/stall
// sequences, then random instructions checked against an instruction-level model.
module tb_mano_control_unit;

  logic        clk = 1'b0;
  logic        rst, run;
  logic [15:0] ir;
  logic        ac_zero, ac_msb, dr_zero, e;
  logic        ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr, dr_ld, dr_inr;
  logic        ac_ld, ac_inr, ac_clr, ir_ld, e_ld, e_clr, e_cmp, mem_rd, mem_wr;
  logic [2:0]  bus_sel, alu_func, sc;
  logic        halted;

  always #5 clk = ~clk;

  mano_control_unit #(.SC_W(3)) dut (
    .clk(clk), .rst(rst), .run(run), .ir(ir),
    .ac_zero(ac_zero), .ac_msb(ac_msb), .dr_zero(dr_zero), .e(e),
    .ar_ld(ar_ld), .ar_inr(ar_inr), .ar_clr(ar_clr),
    .pc_ld(pc_ld), .pc_inr(pc_inr), .pc_clr(pc_clr),
    .dr_ld(dr_ld), .dr_inr(dr_inr),
    .ac_ld(ac_ld), .ac_inr(ac_inr), .ac_clr(ac_clr),
    .ir_ld(ir_ld), .e_ld(e_ld), .e_clr(e_clr), .e_cmp(e_cmp),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .bus_sel(bus_sel), .alu_func(alu_func), .sc(sc), .halted(halted)
  );

  typedef struct packed {
    logic [16:0] stb;
    logic [2:0]  bus;
    logic [2:0]  alu;
  } outs_t;

  localparam logic [16:0] AR_LD  = 17'h10000, AR_INR = 17'h08000, AR_CLR = 17'h04000;
  localparam logic [16:0] PC_LD  = 17'h02000, PC_INR = 17'h01000, PC_CLR = 17'h00800;
  localparam logic [16:0] DR_LD  = 17'h00400, DR_INR = 17'h00200, AC_LD  = 17'h00100;
  localparam logic [16:0] AC_INR = 17'h00080, AC_CLR = 17'h00040, IR_LD  = 17'h00020;
  localparam logic [16:0] E_LD   = 17'h00010, E_CLR  = 17'h00008, E_CMP  = 17'h00004;
  localparam logic [16:0] MEM_RD = 17'h00002, MEM_WR = 17'h00001, NONE   = 17'h00000;
  localparam logic [16:0] ALU_USERS = AC_LD | E_LD;

  typedef struct {
    string       name;
    logic [15:0] ir;
    logic        az, am, dz, ee;
    int          tchk;
    int          len;
    outs_t       exp;
  } vec_t;

  vec_t  vt[$];
  outs_t exp_q[$];
  int    checks = 0;
  int    failures = 0;

  function automatic outs_t mk(input logic [16:0] s, input logic [2:0] b, input logic [2:0] a);
    outs_t o;
    o.stb = s; o.bus = b; o.alu = a;
    return o;
  endfunction

  function automatic outs_t actual();
    outs_t o;
    o.stb = {ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr, dr_ld, dr_inr, ac_ld,
             ac_inr, ac_clr, ir_ld, e_ld, e_clr, e_cmp, mem_rd, mem_wr};
    o.bus = bus_sel;
    o.alu = alu_func;
    return o;
  endfunction

  function automatic void add_vec(input string n, input logic [15:0] w, input logic az, am, dz, ee,
                                  input int tchk, input int len, input logic [16:0] s,
                                  input logic [2:0] b, input logic [2:0] a);
    vec_t v;
    v.name = n; v.ir = w; v.az = az; v.am = am; v.dz = dz; v.ee = ee;
    v.tchk = tchk; v.len = len; v.exp = mk(s, b, a);
    vt.push_back(v);
  endfunction

  task automatic chk(input string name, input outs_t x, input int esc, input logic eh);
    outs_t a;
    bit    ok;
    a = actual();
    checks++;
    ok = (a.stb == x.stb) && (a.bus == x.bus) && (int'(sc) == esc) && (halted == eh);
    if ((x.stb & ALU_USERS) != NONE && a.alu != x.alu) ok = 0;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got stb=%h bus=%0d alu=%0d sc=%0d halted=%0d, want stb=%h bus=%0d alu=%0d sc=%0d halted=%0d",
               name, a.stb, a.bus, a.alu, sc, halted, x.stb, x.bus, x.alu, esc, eh);
    end
  endtask

  task automatic chk_sc(input string name, input int esc);
    checks++;
    if (int'(sc) != esc) begin
      failures++;
      $display("FAIL %s: got sc=%0d, want sc=%0d", name, sc, esc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_chk(input string name, input outs_t x, input int esc, input logic eh);
    @(negedge clk);
    chk(name, x, esc, eh);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Reference model: the whole micro-operation list of one instruction, one entry per cycle.
  function automatic void build(input logic [15:0] w, input logic az, am, dz, ee, output bit hlt);
    int op, hb;
    hlt = 0;
    op  = int'(w[14:12]);
    exp_q.delete();
    exp_q.push_back(mk(AR_LD, 3'd2, 3'd0));
    exp_q.push_back(mk(MEM_RD | IR_LD | PC_INR, 3'd7, 3'd0));
    exp_q.push_back(mk(AR_LD, 3'd5, 3'd0));
    if (op == 7) begin
      if (w[15]) begin
        exp_q.push_back(mk(NONE, 3'd0, 3'd0));
      end else begin
        hb = -1;
        for (int b = 0; b < 12; b++) if (w[b]) hb = b;
        case (hb)
          11: exp_q.push_back(mk(AC_CLR, 3'd0, 3'd0));
          10: exp_q.push_back(mk(E_CLR, 3'd0, 3'd0));
          9:  exp_q.push_back(mk(AC_LD, 3'd0, 3'd3));
          8:  exp_q.push_back(mk(E_CMP, 3'd0, 3'd0));
          7:  exp_q.push_back(mk(AC_LD | E_LD, 3'd0, 3'd4));
          6:  exp_q.push_back(mk(AC_LD | E_LD, 3'd0, 3'd5));
          5:  exp_q.push_back(mk(AC_INR, 3'd0, 3'd0));
          4:  exp_q.push_back(mk(am ? NONE : PC_INR, 3'd0, 3'd0));
          3:  exp_q.push_back(mk(am ? PC_INR : NONE, 3'd0, 3'd0));
          2:  exp_q.push_back(mk(az ? PC_INR : NONE, 3'd0, 3'd0));
          1:  exp_q.push_back(mk(ee ? NONE : PC_INR, 3'd0, 3'd0));
          0:  begin exp_q.push_back(mk(NONE, 3'd0, 3'd0)); hlt = 1; end
          default: exp_q.push_back(mk(NONE, 3'd0, 3'd0));
        endcase
      end
    end else begin
      exp_q.push_back(w[15] ? mk(MEM_RD | AR_LD, 3'd7, 3'd0) : mk(NONE, 3'd0, 3'd0));
      case (op)
        0, 1, 2: begin
          exp_q.push_back(mk(MEM_RD | DR_LD, 3'd7, 3'd0));
          exp_q.push_back(mk(AC_LD | (op == 1 ? E_LD : NONE), 3'd0,
                             op == 0 ? 3'd1 : (op == 1 ? 3'd2 : 3'd0)));
        end
        3: exp_q.push_back(mk(MEM_WR, 3'd4, 3'd0));
        4: exp_q.push_back(mk(PC_LD, 3'd1, 3'd0));
        5: begin
          exp_q.push_back(mk(MEM_WR | AR_INR, 3'd2, 3'd0));
          exp_q.push_back(mk(PC_LD, 3'd1, 3'd0));
        end
        default: begin
          exp_q.push_back(mk(MEM_RD | DR_LD, 3'd7, 3'd0));
          exp_q.push_back(mk(DR_INR, 3'd0, 3'd0));
          exp_q.push_back(mk(MEM_WR | (dz ? PC_INR : NONE), 3'd3, 3'd0));
        end
      endcase
    end
  endfunction

  initial begin
    bit          hlt;
    logic [11:0] low, bitv;
    logic [2:0]  op3;
    logic        ind;
    int          k;

    add_vec("fetch_t0", 16'h7800, 0, 0, 0, 0, 0, 4, AR_LD, 3'd2, 3'd0);
    add_vec("fetch_t1", 16'h7800, 0, 0, 0, 0, 1, 4, MEM_RD | IR_LD | PC_INR, 3'd7, 3'd0);
    add_vec("fetch_t2", 16'h7800, 0, 0, 0, 0, 2, 4, AR_LD, 3'd5, 3'd0);
    add_vec("cla_t3",   16'h7800, 0, 0, 0, 0, 3, 4, AC_CLR, 3'd0, 3'd0);
    add_vec("add_t3",   16'h100A, 0, 0, 0, 0, 3, 6, NONE, 3'd0, 3'd0);
    add_vec("add_t4",   16'h100A, 0, 0, 0, 0, 4, 6, MEM_RD | DR_LD, 3'd7, 3'd0);
    add_vec("add_t5",   16'h100A, 0, 0, 0, 0, 5, 6, AC_LD | E_LD, 3'd0, 3'd2);
    add_vec("and_t5",   16'h000A, 0, 0, 0, 0, 5, 6, AC_LD, 3'd0, 3'd1);
    add_vec("ldai_t3",  16'hA00A, 0, 0, 0, 0, 3, 6, MEM_RD | AR_LD, 3'd7, 3'd0);
    add_vec("ldai_t5",  16'hA00A, 0, 0, 0, 0, 5, 6, AC_LD, 3'd0, 3'd0);
    add_vec("sta_t4",   16'h300A, 0, 0, 0, 0, 4, 5, MEM_WR, 3'd4, 3'd0);
    add_vec("buni_t4",  16'hC00A, 0, 0, 0, 0, 4, 5, PC_LD, 3'd1, 3'd0);
    add_vec("bsa_t4",   16'h500A, 0, 0, 0, 0, 4, 6, MEM_WR | AR_INR, 3'd2, 3'd0);
    add_vec("bsa_t5",   16'h500A, 0, 0, 0, 0, 5, 6, PC_LD, 3'd1, 3'd0);
    add_vec("isz_t5",   16'h600A, 0, 0, 0, 0, 5, 7, DR_INR, 3'd0, 3'd0);
    add_vec("isz_dz1",  16'h600A, 0, 0, 1, 0, 6, 7, MEM_WR | PC_INR, 3'd3, 3'd0);
    add_vec("isz_dz0",  16'h600A, 0, 0, 0, 0, 6, 7, MEM_WR, 3'd3, 3'd0);
    add_vec("sza_az1",  16'h7004, 1, 0, 0, 0, 3, 4, PC_INR, 3'd0, 3'd0);
    add_vec("sza_az0",  16'h7004, 0, 0, 0, 0, 3, 4, NONE, 3'd0, 3'd0);
    add_vec("spa_pos",  16'h7010, 0, 0, 0, 0, 3, 4, PC_INR, 3'd0, 3'd0);
    add_vec("sna_neg",  16'h7008, 0, 1, 0, 0, 3, 4, PC_INR, 3'd0, 3'd0);
    add_vec("sze_e1",   16'h7002, 0, 0, 0, 1, 3, 4, NONE, 3'd0, 3'd0);
    add_vec("cir_prio", 16'h70C0, 0, 0, 0, 0, 3, 4, AC_LD | E_LD, 3'd0, 3'd4);
    add_vec("cil",      16'h7040, 0, 0, 0, 0, 3, 4, AC_LD | E_LD, 3'd0, 3'd5);
    add_vec("cma",      16'h7200, 0, 0, 0, 0, 3, 4, AC_LD, 3'd0, 3'd3);
    add_vec("cme",      16'h7100, 0, 0, 0, 0, 3, 4, E_CMP, 3'd0, 3'd0);
    add_vec("cle",      16'h7400, 0, 0, 0, 0, 3, 4, E_CLR, 3'd0, 3'd0);
    add_vec("cla_prio", 16'h7FFF, 0, 0, 0, 0, 3, 4, AC_CLR, 3'd0, 3'd0);
    add_vec("inc",      16'h7020, 0, 0, 0, 0, 3, 4, AC_INR, 3'd0, 3'd0);
    add_vec("nop",      16'h7000, 0, 0, 0, 0, 3, 4, NONE, 3'd0, 3'd0);
    add_vec("io_nop",   16'hF800, 0, 0, 0, 0, 3, 4, NONE, 3'd0, 3'd0);

    rst = 1'b1; run = 1'b1; ir = 16'h7800;
    ac_zero = 1'b0; ac_msb = 1'b0; dr_zero = 1'b0; e = 1'b0;
    step();
    @(negedge clk);
    chk("reset_state", mk(NONE, 3'd0, 3'd0), 0, 1'b0);

    for (int n = 0; n < vt.size(); n++) begin
      do_reset();
      ir = vt[n].ir; ac_zero = vt[n].az; ac_msb = vt[n].am; dr_zero = vt[n].dz; e = vt[n].ee;
      for (int t = 0; t < vt[n].len; t++) begin
        @(negedge clk);
        if (t == vt[n].tchk) chk(vt[n].name, vt[n].exp, t, 1'b0);
        else chk_sc(vt[n].name, t);
        step();
      end
      @(negedge clk);
      chk_sc({vt[n].name, "_len"}, 0);
    end

    // HLT: halted rises after T3, then nothing until reset.
    do_reset();
    ir = 16'h7001; ac_zero = 1'b0; ac_msb = 1'b0; dr_zero = 1'b0; e = 1'b0;
    for (int t = 0; t < 3; t++) begin @(negedge clk); chk_sc("hlt_fetch", t); step(); end
    cyc_chk("hlt_t3", mk(NONE, 3'd0, 3'd0), 3, 1'b0);
    repeat (10) cyc_chk("hlt_idle", mk(NONE, 3'd0, 3'd0), 0, 1'b1);
    rst = 1'b1;
    cyc_chk("hlt_rst_cycle", mk(NONE, 3'd0, 3'd0), 0, 1'b1);
    rst = 1'b0;
    cyc_chk("hlt_after_rst", mk(AR_LD, 3'd2, 3'd0), 0, 1'b0);

    // Reset during BSA T4 must suppress the memory write.
    do_reset();
    ir = 16'h500A;
    for (int t = 0; t < 4; t++) begin @(negedge clk); chk_sc("bsa_pre", t); step(); end
    rst = 1'b1;
    cyc_chk("bsa_rst_t4", mk(NONE, 3'd0, 3'd0), 4, 1'b0);
    rst = 1'b0;
    cyc_chk("bsa_after_rst", mk(AR_LD, 3'd2, 3'd0), 0, 1'b0);

    // Stall at T5 of ADD for three cycles.
    do_reset();
    ir = 16'h100A;
    for (int t = 0; t < 5; t++) begin @(negedge clk); chk_sc("add_pre", t); step(); end
    run = 1'b0;
    repeat (3) cyc_chk("add_stall", mk(NONE, 3'd0, 3'd0), 5, 1'b0);
    run = 1'b1;
    cyc_chk("add_resume", mk(AC_LD | E_LD, 3'd0, 3'd2), 5, 1'b0);
    cyc_chk("add_next_t0", mk(AR_LD, 3'd2, 3'd0), 0, 1'b0);

    // Random instructions with random stalls against the model.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      op3 = 3'($urandom_range(0, 7));
      ind = 1'($urandom_range(0, 1));
      k   = int'($urandom_range(0, 12));
      if (k == 12) begin
        low = 12'h000;
      end else begin
        bitv = 12'd1 << k;
        low  = bitv | (12'($urandom) & (bitv - 12'd1));
      end
      ir = {ind, op3, low};
      ac_zero = 1'($urandom); ac_msb = 1'($urandom); dr_zero = 1'($urandom); e = 1'($urandom);
      build(ir, ac_zero, ac_msb, dr_zero, e, hlt);
      for (int t = 0; t < exp_q.size(); t++) begin
        if ($urandom_range(0, 7) == 0) begin
          run = 1'b0;
          repeat ($urandom_range(1, 2)) cyc_chk($sformatf("rnd_stall_%h_T%0d", ir, t), mk(NONE, 3'd0, 3'd0), t, 1'b0);
          run = 1'b1;
        end
        cyc_chk($sformatf("rnd_%h_T%0d", ir, t), exp_q[t], t, 1'b0);
      end
      if (hlt) begin
        repeat (2) cyc_chk("rnd_halted", mk(NONE, 3'd0, 3'd0), 0, 1'b1);
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mano_control_unit.md
# mano_control_unit

Hardwired control unit for the Mano basic-computer core. It owns the sequence counter (T0–T6), the indirect flip-flop I and the halt flag. It decodes IR and the datapath status bits, and drives every register load/clear/increment strobe, the common-bus select, the ALU function and the memory read/write strobes. It replaces the inline control logic in the core, and the datapath registers, bus mux, ALU and memory instantiate around it.

## Interface
- SC_W, 3, sequence-counter width; must hold T0–T6.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- run  in  1  advance enable; low stalls SC with all strobes 0.
- ir  in  16  instruction register contents.
- ac_zero, ac_msb, dr_zero, e  in  1 each  datapath status.
- ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr, dr_ld, dr_inr, ac_ld, ac_inr, ac_clr, ir_ld, e_ld, e_clr, e_cmp  out  1 each  register strobes.
- mem_rd, mem_wr  out  1  memory strobes (address = AR, write data = bus).
- bus_sel  out  3  000 none, 001 AR, 010 PC, 011 DR, 100 AC, 101 IR, 110 TR, 111 MEM.
- alu_func  out  3  000 pass DR, 001 AND, 010 ADD (carry→E), 011 COM AC, 100 SHR via E, 101 SHL via E.
- sc  out  SC_W  current timing state (debug).
- halted  out  1  HLT executed.

## Operation
- Registered state: sc, i, halted. All strobes are combinational from sc, ir, i, status, run, halted, rst.
- Reset values: sc=0, i=0, halted=0. While rst=1, all strobes are 0 and bus_sel=000.
- Fetch/decode, common to all instructions:
  - T0: bus PC, ar_ld.
  - T1: bus MEM, mem_rd, ir_ld, pc_inr.
  - T2: bus IR, ar_ld; i←ir[15] at the end of T2.
- Opcode ir[14:12]=7 with I=0 is register-reference. It executes in T3 and then SC clears.
  - The highest set bit of ir[11:0] selects the operation:
    - 800 CLA: ac_clr.
    - 400 CLE: e_clr.
    - 200 CMA: alu 011, ac_ld.
    - 100 CME: e_cmp.
    - 080 CIR: alu 100, ac_ld, e_ld.
    - 040 CIL: alu 101, ac_ld, e_ld.
    - 020 INC: ac_inr.
    - 010 SPA: pc_inr if !ac_msb.
    - 008 SNA: pc_inr if ac_msb.
    - 004 SZA: pc_inr if ac_zero.
    - 002 SZE: pc_inr if !e.
    - 001 HLT: halted←1.
  - ir[11:0]=0 is a NOP.
- Opcode 7 with I=1 (I/O) is a NOP: SC clears at T3.
- Memory-reference, T3: if I=1, bus MEM, mem_rd, ar_ld; else idle. Then:
  - AND/ADD/LDA (0/1/2): T4 bus MEM, mem_rd, dr_ld. T5 ac_ld with alu 001/010/000; ADD also e_ld. SC clears.
  - STA (3): T4 bus AC, mem_wr; SC clears.
  - BUN (4): T4 bus AR, pc_ld; SC clears.
  - BSA (5): T4 bus PC, mem_wr, ar_inr. T5 bus AR, pc_ld; SC clears.
  - ISZ (6): T4 bus MEM, mem_rd, dr_ld. T5 dr_inr. T6 bus DR, mem_wr, pc_inr if dr_zero; SC clears.
- "SC clears" means sc=0 on the next edge. Otherwise sc increments.
- Halted: sc is held at 0 and all strobes are 0. Only rst clears halted.

## Timing
- Instruction length in cycles:
  - Register-ref and I/O: 4.
  - STA, BUN: 5 direct, +0 indirect (T3 is always spent).
  - AND/ADD/LDA, BSA: 6.
  - ISZ: 7.
- run=0 at any T-state: sc, i and halted hold and all strobes are 0. Execution resumes in the same T-state when run returns to 1.
- rst mid-instruction wins over everything. Its cycle issues no strobes, so no partial mem_wr occurs, and the next cycle is T0.
- HLT: halted rises on the edge ending T3. From the next cycle sc=0 with no T0 strobes.
- Status inputs are sampled in the same cycle they are used; dr_zero at T6 reflects the incremented DR.

## Structure
- Package mano_pkg holds:
  - bus_sel codes, alu_func codes, opcode constants (AND…ISZ, REGREF=7);
  - register-reference bit masks;
  - a T-state enum (T0–T6).
- Sub-module mano_decode: combinational ir → opcode one-hot, regref one-hot (highest-bit priority), is_regref, is_io.

## Test plan
- **Fetch + CLA.** rst, then run=1, ir=7800 at T2. Required strobes:
  - T0: bus 010, ar_ld.
  - T1: bus 111, mem_rd, ir_ld, pc_inr.
  - T2: bus 101, ar_ld.
  - T3: ac_clr.
  - Next cycle sc=0.
- **Direct ADD**, ir=100A:
  - T3: no strobes.
  - T4: bus 111, mem_rd, dr_ld.
  - T5: alu 010, ac_ld, e_ld.
  - Total 6 cycles.
- **Indirect LDA**, ir=A00A:
  - i=1 after T2.
  - T3: bus 111, ar_ld.
  - T5: alu 000, ac_ld.
- **ISZ**, ir=600A:
  - dr_zero=1 at T6: bus 011, mem_wr, pc_inr.
  - Repeat with dr_zero=0: mem_wr without pc_inr.
- **SZA and HLT.**
  - ir=7004, ac_zero=1: pc_inr at T3. With ac_zero=0: no pc_inr.
  - ir=7001: halted=1, then sc stays 0 with no strobes for 10 cycles; rst clears halted.
- **Reset and stall.**
  - rst asserted during T4 of BSA (ir=500A): that cycle has no mem_wr; next cycle is T0.
  - run=0 at T5 of ADD for 3 cycles: no ac_ld until resume.
